// File: rtl/dfi_init_if.sv
// ----------------------------------------------------------------------------
// dfi_init_if
// Purpose : DFI signals exchanged between a memory controller and the PHY
//           during DDR3 power-up and the DFI init handshake.
// Signals : dfi_reset_n, dfi_cke             - DRAM reset / clock enable
//           dfi_cs_n/ras_n/cas_n/we_n        - command bits
//           dfi_bank[2:0]                    - bank address (MR index on MRS)
//           dfi_init_start                   - init request from controller
//           dfi_init_complete                - init response from PHY side
// Modports: master - controller side (drives command/reset/start)
//           slave  - PHY side (samples command, drives init_complete)
// ----------------------------------------------------------------------------
interface dfi_init_if;
    logic       dfi_reset_n;
    logic       dfi_cke;
    logic       dfi_cs_n;
    logic       dfi_ras_n;
    logic       dfi_cas_n;
    logic       dfi_we_n;
    logic [2:0] dfi_bank;
    logic       dfi_init_start;
    logic       dfi_init_complete;

    modport master (
        output dfi_reset_n, dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n,
        output dfi_bank, dfi_init_start,
        input  dfi_init_complete
    );

    modport slave (
        input  dfi_reset_n, dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n,
        input  dfi_bank, dfi_init_start,
        output dfi_init_complete
    );
endinterface

// File: rtl/dfi_init_responder.sv
// ----------------------------------------------------------------------------
// dfi_init_responder
// Purpose : PHY-side counterpart of the controller init sequencer. Watches the
//           DDR3 power-up sequence on the DFI (reset, CKE, MR2/MR3/MR1/MR0,
//           ZQCL), enforces its timing and order, latches the first violation
//           as a sticky error code, and answers the DFI init handshake.
// Ports   : core_clk          - clock, rising edge
//           core_arstn        - asynchronous active-low reset
//           dfi               - DFI slave modport (command in, init_complete out)
//           dram_init_done    - full power-up sequence observed
//           init_error        - sticky violation flag
//           init_err_code     - code of first violation (0 = none)
//             1 reset too short, 2 CKE too early, 3 command inside tXPR,
//             4 MRS out of order, 5 unexpected command, 6 CKE dropped
// ----------------------------------------------------------------------------
module dfi_init_responder #(
    parameter int unsigned T_RESET_MIN     = 16,
    parameter int unsigned T_CKE_WAIT      = 32,
    parameter int unsigned T_XPR           = 8,
    parameter int unsigned T_ZQINIT        = 16,
    parameter int unsigned PHY_INIT_CYCLES = 4
) (
    input  logic       core_clk,
    input  logic       core_arstn,
    dfi_init_if.slave  dfi,
    output logic       dram_init_done,
    output logic       init_error,
    output logic [2:0] init_err_code
);

    localparam logic [15:0] T_RESET_MIN_C = 16'(T_RESET_MIN);
    localparam logic [15:0] T_CKE_WAIT_C  = 16'(T_CKE_WAIT);
    localparam logic [15:0] T_XPR_C       = 16'(T_XPR);
    localparam logic [15:0] ZQ_LAST_C     = 16'(T_ZQINIT - 32'd1);
    localparam logic [15:0] CAL_LAST_C    = 16'(PHY_INIT_CYCLES - 32'd1);

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_RESET = 3'd1;
    localparam logic [2:0] ERR_CKE   = 3'd2;
    localparam logic [2:0] ERR_XPR   = 3'd3;
    localparam logic [2:0] ERR_ORDER = 3'd4;
    localparam logic [2:0] ERR_CMD   = 3'd5;
    localparam logic [2:0] ERR_CKEDN = 3'd6;

    typedef enum logic [3:0] {
        ST_RST_LOW  = 4'd0,
        ST_WAIT_CKE = 4'd1,
        ST_WAIT_XPR = 4'd2,
        ST_MRS2     = 4'd3,
        ST_MRS3     = 4'd4,
        ST_MRS1     = 4'd5,
        ST_MRS0     = 4'd6,
        ST_ZQ       = 4'd7,
        ST_ZQ_WAIT  = 4'd8,
        ST_DONE     = 4'd9,
        ST_ERROR    = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        CMD_NOP     = 2'd0,
        CMD_MRS     = 2'd1,
        CMD_ZQCL    = 2'd2,
        CMD_ILLEGAL = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_CAL  = 2'd1,
        H_DONE = 2'd2
    } hs_e;

    // Saturating increment: the counter parks at 0xFFFF instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

    // MR index expected in a given state. WAIT_XPR behaves like MRS2 once tXPR is met.
    function automatic logic [2:0] mrs_index(input state_e s);
        logic [2:0] r;
        case (s)
            ST_WAIT_XPR: r = 3'd2;
            ST_MRS2:     r = 3'd2;
            ST_MRS3:     r = 3'd3;
            ST_MRS1:     r = 3'd1;
            ST_MRS0:     r = 3'd0;
            default:     r = 3'd7;
        endcase
        return r;
    endfunction

    // Successor state after the correct MRS in a given state.
    function automatic state_e mrs_next(input state_e s);
        state_e r;
        case (s)
            ST_WAIT_XPR: r = ST_MRS3;
            ST_MRS2:     r = ST_MRS3;
            ST_MRS3:     r = ST_MRS1;
            ST_MRS1:     r = ST_MRS0;
            ST_MRS0:     r = ST_ZQ;
            default:     r = ST_ERROR;
        endcase
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [2:0]  code_q, code_d;
    hs_e         hs_q, hs_d;
    logic [15:0] hcnt_q, hcnt_d;
    logic        cmp_q, cmp_d;

    cmd_e        cmd_s;
    logic        viol_s;
    logic [2:0]  viol_code_s;

    // Command decode of the sampled DFI command bits.
    always_comb begin
        cmd_s = CMD_ILLEGAL;
        if (dfi.dfi_cs_n || ({dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} == 3'b111)) begin
            cmd_s = CMD_NOP;
        end else if ({dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} == 3'b000) begin
            cmd_s = CMD_MRS;
        end else if ({dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} == 3'b110) begin
            cmd_s = CMD_ZQCL;
        end else begin
            cmd_s = CMD_ILLEGAL;
        end
    end

    // Main power-up FSM: next state, counter and sticky status.
    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        err_d       = err_q;
        code_d      = code_q;
        viol_s      = 1'b0;
        viol_code_s = ERR_NONE;
        if ((state_q != ST_RST_LOW) && !dfi.dfi_reset_n) begin
            // Re-init from any state wins over everything else this cycle.
            state_d = ST_RST_LOW;
            done_d  = 1'b0;
            err_d   = 1'b0;
            code_d  = ERR_NONE;
        end else begin
            case (state_q)
                ST_RST_LOW: begin
                    if (dfi.dfi_reset_n) begin
                        if (cnt_q >= T_RESET_MIN_C) begin
                            state_d = ST_WAIT_CKE;
                        end else begin
                            viol_s      = 1'b1;
                            viol_code_s = ERR_RESET;
                        end
                    end else begin
                        state_d = ST_RST_LOW;
                    end
                end
                ST_WAIT_CKE: begin
                    if (dfi.dfi_cke) begin
                        if (cnt_q >= T_CKE_WAIT_C) begin
                            state_d = ST_WAIT_XPR;
                        end else begin
                            viol_s      = 1'b1;
                            viol_code_s = ERR_CKE;
                        end
                    end else begin
                        state_d = ST_WAIT_CKE;
                    end
                end
                ST_WAIT_XPR, ST_MRS2, ST_MRS3, ST_MRS1, ST_MRS0: begin
                    if (!dfi.dfi_cke) begin
                        viol_s      = 1'b1;
                        viol_code_s = ERR_CKEDN;
                    end else if (cmd_s == CMD_NOP) begin
                        state_d = state_q;
                    end else if ((state_q == ST_WAIT_XPR) && (cnt_q < T_XPR_C)) begin
                        viol_s      = 1'b1;
                        viol_code_s = ERR_XPR;
                    end else if (cmd_s == CMD_MRS) begin
                        if (dfi.dfi_bank == mrs_index(state_q)) begin
                            state_d = mrs_next(state_q);
                        end else begin
                            viol_s      = 1'b1;
                            viol_code_s = ERR_ORDER;
                        end
                    end else begin
                        viol_s      = 1'b1;
                        viol_code_s = ERR_CMD;
                    end
                end
                ST_ZQ: begin
                    if (!dfi.dfi_cke) begin
                        viol_s      = 1'b1;
                        viol_code_s = ERR_CKEDN;
                    end else if (cmd_s == CMD_ZQCL) begin
                        state_d = ST_ZQ_WAIT;
                    end else if (cmd_s != CMD_NOP) begin
                        viol_s      = 1'b1;
                        viol_code_s = ERR_CMD;
                    end else begin
                        state_d = ST_ZQ;
                    end
                end
                ST_ZQ_WAIT: begin
                    if (!dfi.dfi_cke) begin
                        viol_s      = 1'b1;
                        viol_code_s = ERR_CKEDN;
                    end else if (cmd_s != CMD_NOP) begin
                        viol_s      = 1'b1;
                        viol_code_s = ERR_CMD;
                    end else if (cnt_q == ZQ_LAST_C) begin
                        // cnt was cleared on the ZQCL edge, so this is edge ZQCL+T_ZQINIT.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ZQ_WAIT;
                    end
                end
                ST_DONE:  state_d = ST_DONE;
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_ERROR;
            endcase
            if (viol_s) begin
                state_d = ST_ERROR;
                err_d   = 1'b1;
                code_d  = viol_code_s;
            end else begin
                err_d   = err_q;
            end
        end
        // Counter restarts on every state entry so each ">= T" test sees only
        // the cycles spent in the state before the transition cycle.
        if (state_d != state_q) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // Handshake FSM, independent of the power-up sequence.
    always_comb begin
        hs_d  = hs_q;
        cmp_d = cmp_q;
        case (hs_q)
            H_IDLE: begin
                if (dfi.dfi_init_start) begin
                    hs_d = H_CAL;
                end else begin
                    hs_d = H_IDLE;
                end
                cmp_d = 1'b0;
            end
            H_CAL: begin
                if (!dfi.dfi_init_start) begin
                    hs_d  = H_IDLE;
                    cmp_d = 1'b0;
                end else if (hcnt_q == CAL_LAST_C) begin
                    hs_d  = H_DONE;
                    cmp_d = 1'b1;
                end else begin
                    hs_d  = H_CAL;
                    cmp_d = 1'b0;
                end
            end
            H_DONE: begin
                if (!dfi.dfi_init_start) begin
                    hs_d  = H_IDLE;
                    cmp_d = 1'b0;
                end else begin
                    hs_d  = H_DONE;
                    cmp_d = 1'b1;
                end
            end
            default: begin
                hs_d  = H_IDLE;
                cmp_d = 1'b0;
            end
        endcase
        if (hs_d != hs_q) begin
            hcnt_d = 16'd0;
        end else begin
            hcnt_d = sat_inc(hcnt_q);
        end
    end

    // State and output registers for both FSMs.
    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            state_q <= ST_RST_LOW;
            cnt_q   <= 16'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            hs_q    <= H_IDLE;
            hcnt_q  <= 16'd0;
            cmp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            hs_q    <= hs_d;
            hcnt_q  <= hcnt_d;
            cmp_q   <= cmp_d;
        end
    end

    assign dfi.dfi_init_complete = cmp_q;
    assign dram_init_done        = done_q;
    assign init_error            = err_q;
    assign init_err_code         = code_q;

endmodule

// File: tb/tb_dfi_init_responder.sv
// ----------------------------------------------------------------------------
// tb_dfi_init_responder
// Self-checking bench for dfi_init_responder with T_RESET_MIN=8, T_CKE_WAIT=20,
// T_XPR=5, T_ZQINIT=10, PHY_INIT_CYCLES=4. Scenario code pushes the expected
// output value and the edge it is due after into a scoreboard; a negedge
// monitor pops and compares entries as they fall due.
// ----------------------------------------------------------------------------
module tb_dfi_init_responder;

    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_MRS  = 4'b0000;
    localparam logic [3:0] C_ZQCL = 4'b0110;
    localparam logic [3:0] C_ILL  = 4'b0001;

    logic       core_clk   = 1'b0;
    logic       core_arstn = 1'b0;
    logic       dram_init_done;
    logic       init_error;
    logic [2:0] init_err_code;

    int n_checks = 0;
    int n_fails  = 0;
    int edge_n   = 0;

    typedef struct {
        int         due;
        bit         hs;
        string      tag;
        logic [4:0] val;
    } exp_t;

    exp_t sb[$];

    dfi_init_if dfi_if ();

    dfi_init_responder #(
        .T_RESET_MIN    (8),
        .T_CKE_WAIT     (20),
        .T_XPR          (5),
        .T_ZQINIT       (10),
        .PHY_INIT_CYCLES(4)
    ) dut (
        .core_clk      (core_clk),
        .core_arstn    (core_arstn),
        .dfi           (dfi_if.slave),
        .dram_init_done(dram_init_done),
        .init_error    (init_error),
        .init_err_code (init_err_code)
    );

    // Clock generator, 10 time-unit period.
    always #5 core_clk = ~core_clk;

    // Edge counter used to schedule scoreboard entries.
    always @(posedge core_clk) edge_n <= edge_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // Scoreboard monitor: compares every entry whose edge has been reached.
    always @(negedge core_clk) begin
        int i;
        logic [4:0] obs;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due <= edge_n) begin
                if (sb[i].hs) obs = {4'd0, dfi_if.dfi_init_complete};
                else          obs = {dram_init_done, init_error, init_err_code};
                chk(sb[i].tag, {27'd0, obs}, {27'd0, sb[i].val});
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    // Expect {done, error, code} right after edge 'due'.
    task automatic exp_main(input int due, input string tag, input logic [4:0] val);
        exp_t e;
        e.due = due; e.hs = 1'b0; e.tag = tag; e.val = val;
        sb.push_back(e);
    endtask

    // Expect dfi_init_complete right after edge 'due'.
    task automatic exp_hs(input int due, input string tag, input logic val);
        exp_t e;
        e.due = due; e.hs = 1'b1; e.tag = tag; e.val = {4'd0, val};
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic drive(input logic rn, input logic cke, input logic [3:0] cmd, input logic [2:0] bank);
        dfi_if.dfi_reset_n = rn;
        dfi_if.dfi_cke     = cke;
        {dfi_if.dfi_cs_n, dfi_if.dfi_ras_n, dfi_if.dfi_cas_n, dfi_if.dfi_we_n} = cmd;
        dfi_if.dfi_bank    = bank;
    endtask

    // One command for one cycle, then back to NOP.
    task automatic send(input logic [3:0] cmd, input logic [2:0] bank);
        drive(1'b1, 1'b1, cmd, bank);
        tick();
        drive(1'b1, 1'b1, C_NOP, 3'd0);
    endtask

    task automatic do_arst();
        core_arstn = 1'b0;
        drive(1'b0, 1'b0, C_NOP, 3'd0);
        dfi_if.dfi_init_start = 1'b0;
        tick();
        #2 core_arstn = 1'b1;
    endtask

    // reset_n low n_low cycles, rise, CKE after n_wait more cycles, n_nop NOPs.
    task automatic prefix(input int n_low, input int n_wait, input int n_nop);
        drive(1'b0, 1'b0, C_NOP, 3'd0);
        repeat (n_low) tick();
        drive(1'b1, 1'b0, C_NOP, 3'd0);
        tick();
        repeat (n_wait) tick();
        drive(1'b1, 1'b1, C_NOP, 3'd0);
        tick();
        repeat (n_nop) tick();
    endtask

    // Full legal sequence; done must rise exactly 10 edges after ZQCL.
    task automatic legal_seq(input string tag);
        prefix(8, 20, 5);
        exp_main(edge_n + 1, {tag, "_after_prefix"}, 5'b00000);
        send(C_MRS, 3'd2);
        send(C_MRS, 3'd3);
        send(C_MRS, 3'd1);
        send(C_MRS, 3'd0);
        send(C_ZQCL, 3'd0);
        exp_main(edge_n + 9,  {tag, "_zq_minus1"}, 5'b00000);
        exp_main(edge_n + 10, {tag, "_done"},      5'b10000);
        exp_main(edge_n + 12, {tag, "_done_hold"}, 5'b10000);
        repeat (13) tick();
    endtask

    initial begin
        dfi_if.dfi_init_start = 1'b0;
        drive(1'b0, 1'b0, C_NOP, 3'd0);
        #1;
        chk("rst_done",  {31'd0, dram_init_done}, 32'd0);
        chk("rst_error", {31'd0, init_error}, 32'd0);
        chk("rst_code",  {29'd0, init_err_code}, 32'd0);
        chk("rst_cmp",   {31'd0, dfi_if.dfi_init_complete}, 32'd0);
        tick();
        #2 core_arstn = 1'b1;

        // Legal power-up sequence.
        legal_seq("legal");

        // reset_n low one cycle short -> code 1, held afterwards.
        do_arst();
        drive(1'b0, 1'b0, C_NOP, 3'd0);
        repeat (7) tick();
        drive(1'b1, 1'b0, C_NOP, 3'd0);
        exp_main(edge_n + 2, "rst_short", 5'b01001);
        exp_main(edge_n + 5, "rst_short_hold", 5'b01001);
        repeat (6) tick();

        // CKE one cycle early -> code 2.
        do_arst();
        drive(1'b0, 1'b0, C_NOP, 3'd0);
        repeat (8) tick();
        drive(1'b1, 1'b0, C_NOP, 3'd0);
        tick();
        repeat (19) tick();
        drive(1'b1, 1'b1, C_NOP, 3'd0);
        exp_main(edge_n + 2, "cke_early", 5'b01010);
        repeat (3) tick();

        // MRS four cycles after CKE -> code 3.
        do_arst();
        prefix(8, 20, 3);
        exp_main(edge_n + 2, "xpr_early", 5'b01011);
        send(C_MRS, 3'd2);
        repeat (3) tick();

        // MR2 then MR1 -> code 4; later ILLEGAL leaves it at 4; then re-init.
        do_arst();
        prefix(8, 20, 5);
        send(C_MRS, 3'd2);
        exp_main(edge_n + 2, "order", 5'b01100);
        send(C_MRS, 3'd1);
        tick();
        exp_main(edge_n + 2, "order_sticky", 5'b01100);
        send(C_ILL, 3'd0);
        tick();
        drive(1'b0, 1'b0, C_NOP, 3'd0);
        exp_main(edge_n + 2, "reinit_clr", 5'b00000);
        tick();
        legal_seq("reinit");

        // ZQCL before MR0 -> code 5.
        do_arst();
        prefix(8, 20, 5);
        send(C_MRS, 3'd2);
        send(C_MRS, 3'd3);
        send(C_MRS, 3'd1);
        exp_main(edge_n + 2, "zq_early", 5'b01101);
        send(C_ZQCL, 3'd0);
        repeat (3) tick();

        // CKE dropped during the MRS phase -> code 6.
        do_arst();
        prefix(8, 20, 5);
        send(C_MRS, 3'd2);
        drive(1'b1, 1'b0, C_NOP, 3'd0);
        exp_main(edge_n + 2, "cke_drop", 5'b01110);
        repeat (3) tick();

        // Handshake: rise after 4 edges, fall, re-assert, abort.
        do_arst();
        tick();
        dfi_if.dfi_init_start = 1'b1;
        tick();
        exp_hs(edge_n + 3, "hs_early", 1'b0);
        exp_hs(edge_n + 4, "hs_rise",  1'b1);
        repeat (5) tick();
        exp_hs(edge_n + 1, "hs_hold", 1'b1);
        tick();
        dfi_if.dfi_init_start = 1'b0;
        exp_hs(edge_n + 2, "hs_fall", 1'b0);
        tick();
        dfi_if.dfi_init_start = 1'b1;
        tick();
        exp_hs(edge_n + 3, "hs_re_early", 1'b0);
        exp_hs(edge_n + 4, "hs_re_rise",  1'b1);
        repeat (5) tick();
        dfi_if.dfi_init_start = 1'b0;
        repeat (3) tick();
        dfi_if.dfi_init_start = 1'b1;
        tick();
        tick();
        dfi_if.dfi_init_start = 1'b0;
        tick();
        exp_hs(edge_n + 2, "hs_abort_a", 1'b0);
        exp_hs(edge_n + 3, "hs_abort_b", 1'b0);
        exp_hs(edge_n + 6, "hs_abort_c", 1'b0);
        repeat (8) tick();

        // core_arstn pulse in ZQ_WAIT with the handshake complete.
        do_arst();
        dfi_if.dfi_init_start = 1'b1;
        prefix(8, 20, 5);
        send(C_MRS, 3'd2);
        send(C_MRS, 3'd3);
        send(C_MRS, 3'd1);
        send(C_MRS, 3'd0);
        send(C_ZQCL, 3'd0);
        repeat (3) tick();
        chk("arst_pre_cmp", {31'd0, dfi_if.dfi_init_complete}, 32'd1);
        #1 core_arstn = 1'b0;
        #1;
        chk("arst_cmp",  {31'd0, dfi_if.dfi_init_complete}, 32'd0);
        chk("arst_main", {27'd0, dram_init_done, init_error, init_err_code}, 32'd0);
        dfi_if.dfi_init_start = 1'b0;
        #1 core_arstn = 1'b1;
        // Back in RST_LOW with an empty counter: reset_n high is now too short.
        exp_main(edge_n + 2, "arst_rst_low", 5'b01001);
        repeat (4) tick();

        chk("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

endmodule
